// File: rtl/llr_loader.sv
// LLR loader: accepts upstream LLR words, shift-writes them into the LLR
// memory one frame at a time, starts the decoder per frame and reports job
// completion. The configuration is latched when a job starts.
module llr_loader #(
  parameter int DATA_W  = 64,
  parameter int FRAME_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [1:0]         i_n_sel,
  input  logic [FRAME_W-1:0] i_num_frames,
  input  logic               i_abort,
  input  logic               i_in_valid,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_in_ready,
  output logic               o_mem_wen,
  output logic [DATA_W-1:0]  o_mem_data,
  output logic               o_dec_start,
  input  logic               i_dec_done,
  output logic [FRAME_W-1:0] o_frame_idx,
  output logic               o_busy,
  output logic               o_all_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_DEC      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]         state;
  logic [6:0]         word_cnt;
  logic [6:0]         last_word;
  logic [1:0]         n_sel_q;
  logic [FRAME_W-1:0] num_frames_q;
  logic [FRAME_W-1:0] frame_idx;
  logic               accept;
  logic               last_frame;

  assign o_in_ready  = (state == S_LOAD);
  assign o_busy      = (state != S_IDLE);
  assign o_all_done  = (state == S_DONE);
  assign o_frame_idx = frame_idx;
  assign accept      = i_in_valid && o_in_ready;
  assign last_frame  = (frame_idx == num_frames_q - FRAME_W'(1));

  // Index of the final word of a frame for the latched code length.
  always_comb begin
    last_word = 7'd15;
    case (n_sel_q)
      2'd0:    last_word = 7'd15;
      2'd1:    last_word = 7'd31;
      2'd2:    last_word = 7'd63;
      default: last_word = 7'd127;
    endcase
  end

  // Control FSM, word/frame counters, config latch and registered write port.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      frame_idx    <= '0;
      n_sel_q      <= '0;
      num_frames_q <= '0;
      o_mem_wen    <= 1'b0;
      o_mem_data   <= '0;
      o_dec_start  <= 1'b0;
    end else begin
      // Abort outranks a word offered in the same cycle, so it is not written.
      o_mem_wen   <= accept && !i_abort;
      if (accept && !i_abort) o_mem_data <= i_in_data;
      o_dec_start <= 1'b0;
      if (i_abort) begin
        state    <= S_IDLE;
        word_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              if (i_num_frames != '0) begin
                n_sel_q      <= i_n_sel;
                num_frames_q <= i_num_frames;
                word_cnt     <= '0;
                frame_idx    <= '0;
                state        <= S_LOAD;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_LOAD: begin
            if (accept) begin
              if (word_cnt == last_word) begin
                word_cnt <= '0;
                state    <= S_WAIT_MEM;
              end else begin
                word_cnt <= word_cnt + 7'd1;
              end
            end
          end
          // One cycle for the final memory write to land before decoding.
          S_WAIT_MEM: begin
            o_dec_start <= 1'b1;
            state       <= S_DEC;
          end
          S_DEC: begin
            if (i_dec_done) begin
              if (last_frame) begin
                state <= S_DONE;
              end else begin
                frame_idx <= frame_idx + FRAME_W'(1);
                state     <= S_LOAD;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_llr_loader.sv
// Directed testbench for llr_loader: single frame, multi-frame with gaps,
// empty job, abort, spurious events and reset during decode.
module tb_llr_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_n_sel = '0;
  logic [7:0]  i_num_frames = '0;
  logic        i_abort = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [63:0] i_in_data = '0;
  logic        o_in_ready;
  logic        o_mem_wen;
  logic [63:0] o_mem_data;
  logic        o_dec_start;
  logic        i_dec_done = 1'b0;
  logic [7:0]  o_frame_idx;
  logic        o_busy;
  logic        o_all_done;

  int total = 0;
  int bad = 0;

  // Activity counters, updated away from the active edge.
  int          wr_cnt = 0;
  int          dec_cnt = 0;
  int          done_cnt = 0;
  logic [63:0] wr_sum = '0;

  llr_loader #(.DATA_W(64), .FRAME_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_n_sel(i_n_sel),
    .i_num_frames(i_num_frames), .i_abort(i_abort), .i_in_valid(i_in_valid),
    .i_in_data(i_in_data), .o_in_ready(o_in_ready), .o_mem_wen(o_mem_wen),
    .o_mem_data(o_mem_data), .o_dec_start(o_dec_start), .i_dec_done(i_dec_done),
    .o_frame_idx(o_frame_idx), .o_busy(o_busy), .o_all_done(o_all_done)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_mem_wen) begin
      wr_cnt = wr_cnt + 1;
      wr_sum = wr_sum + o_mem_data;
    end
    if (o_dec_start) dec_cnt = dec_cnt + 1;
    if (o_all_done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({o_in_ready, o_mem_wen, o_dec_start, o_busy, o_all_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {o_in_ready, o_mem_wen, o_dec_start, o_busy, o_all_done});
    end
    total++;
    if (o_mem_data !== 64'd0 || o_frame_idx !== 8'd0) begin
      bad++;
      $display("FAIL reset_data got data=%h idx=%0d want 0/0", o_mem_data, o_frame_idx);
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int w0;
    i_n_sel = 2'd0;
    i_num_frames = 8'd1;
    pulse_start();
    total++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL sf_load got ready=%b busy=%b want 1/1", o_in_ready, o_busy);
    end
    w0 = wr_cnt;
    for (int k = 0; k < 16; k++) begin
      i_in_valid = 1'b1;
      i_in_data = 64'(k);
      tick();
      total++;
      if (o_mem_wen !== 1'b1 || o_mem_data !== 64'(k)) begin
        bad++;
        $display("FAIL sf_write%0d got wen=%b data=%0d want 1/%0d", k, o_mem_wen, o_mem_data, k);
      end
    end
    total++;
    if (o_in_ready !== 1'b0 || o_dec_start !== 1'b0) begin
      bad++;
      $display("FAIL sf_wait got ready=%b dec=%b want 0/0", o_in_ready, o_dec_start);
    end
    tick();
    total++;
    if (o_dec_start !== 1'b1 || o_mem_wen !== 1'b0) begin
      bad++;
      $display("FAIL sf_dec_start got dec=%b wen=%b want 1/0", o_dec_start, o_mem_wen);
    end
    tick();
    i_in_valid = 1'b0;
    total++;
    if (o_dec_start !== 1'b0 || o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL sf_dec got dec=%b busy=%b ready=%b want 0/1/0", o_dec_start, o_busy, o_in_ready);
    end
    i_dec_done = 1'b1;
    tick();
    i_dec_done = 1'b0;
    total++;
    if (o_all_done !== 1'b1) begin
      bad++;
      $display("FAIL sf_all_done got=%b want=1", o_all_done);
    end
    tick();
    total++;
    if (o_all_done !== 1'b0 || o_busy !== 1'b0 || wr_cnt - w0 != 16) begin
      bad++;
      $display("FAIL sf_end got done=%b busy=%b writes=%0d want 0/0/16",
               o_all_done, o_busy, wr_cnt - w0);
    end
  endtask

  task automatic test_multi_frame();
    int w0, d0, acc, cyc;
    logic [63:0] s0, exp_sum;
    s0 = wr_sum;
    d0 = dec_cnt;
    exp_sum = '0;
    i_n_sel = 2'd3;
    i_num_frames = 8'd3;
    pulse_start();
    // Config changes after start must not affect the running job.
    i_n_sel = 2'd0;
    i_num_frames = 8'd1;
    for (int f = 0; f < 3; f++) begin
      w0 = wr_cnt;
      acc = 0;
      cyc = 0;
      while (acc < 128 && cyc < 600) begin
        i_in_valid = ((cyc % 4) != 2);
        i_in_data = 64'(f * 4096 + acc * 3 + 1);
        if (i_in_valid) begin
          exp_sum = exp_sum + i_in_data;
          acc++;
        end
        tick();
        cyc++;
      end
      i_in_valid = 1'b0;
      total++;
      if (o_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL mf_wait%0d got ready=%b want=0", f, o_in_ready);
      end
      tick();
      total++;
      if (o_dec_start !== 1'b1 || o_frame_idx !== 8'(f)) begin
        bad++;
        $display("FAIL mf_dec%0d got dec=%b idx=%0d want 1/%0d", f, o_dec_start, o_frame_idx, f);
      end
      i_in_valid = 1'b1;
      i_in_data = 64'hDEAD;
      tick();
      tick();
      i_in_valid = 1'b0;
      total++;
      if (o_in_ready !== 1'b0 || wr_cnt - w0 != 128) begin
        bad++;
        $display("FAIL mf_count%0d got ready=%b writes=%0d want 0/128", f, o_in_ready, wr_cnt - w0);
      end
      i_dec_done = 1'b1;
      tick();
      i_dec_done = 1'b0;
      if (f < 2) begin
        total++;
        if (o_frame_idx !== 8'(f + 1) || o_in_ready !== 1'b1) begin
          bad++;
          $display("FAIL mf_next%0d got idx=%0d ready=%b want %0d/1", f, o_frame_idx, o_in_ready, f + 1);
        end
      end else begin
        total++;
        if (o_all_done !== 1'b1 || o_frame_idx !== 8'd2) begin
          bad++;
          $display("FAIL mf_done got done=%b idx=%0d want 1/2", o_all_done, o_frame_idx);
        end
      end
    end
    tick();
    total++;
    if (o_busy !== 1'b0 || o_frame_idx !== 8'd2 || dec_cnt - d0 != 3 || wr_sum - s0 !== exp_sum) begin
      bad++;
      $display("FAIL mf_end got busy=%b idx=%0d decs=%0d sum=%h want 0/2/3/%h",
               o_busy, o_frame_idx, dec_cnt - d0, wr_sum - s0, exp_sum);
    end
  endtask

  task automatic test_zero_frames();
    int w0, d0;
    w0 = wr_cnt;
    d0 = dec_cnt;
    i_num_frames = 8'd0;
    pulse_start();
    total++;
    if (o_all_done !== 1'b1 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL zf_done got done=%b busy=%b want 1/1", o_all_done, o_busy);
    end
    tick();
    total++;
    if (o_all_done !== 1'b0 || o_busy !== 1'b0 || wr_cnt != w0 || dec_cnt != d0) begin
      bad++;
      $display("FAIL zf_end got done=%b busy=%b writes=%0d decs=%0d want 0/0/0/0",
               o_all_done, o_busy, wr_cnt - w0, dec_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int w0, d0, a0;
    logic [63:0] s0, exp_sum;
    w0 = wr_cnt;
    d0 = dec_cnt;
    a0 = done_cnt;
    i_n_sel = 2'd1;
    i_num_frames = 8'd1;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      i_in_valid = 1'b1;
      i_in_data = 64'(k);
      tick();
    end
    i_in_valid = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ab_idle got busy=%b ready=%b want 0/0", o_busy, o_in_ready);
    end
    i_in_valid = 1'b1;
    tick();
    tick();
    tick();
    i_in_valid = 1'b0;
    tick();
    total++;
    if (o_in_ready !== 1'b0 || wr_cnt - w0 != 10 || dec_cnt != d0 || done_cnt != a0) begin
      bad++;
      $display("FAIL ab_quiet got ready=%b writes=%0d decs=%0d dones=%0d want 0/10/0/0",
               o_in_ready, wr_cnt - w0, dec_cnt - d0, done_cnt - a0);
    end
    w0 = wr_cnt;
    s0 = wr_sum;
    exp_sum = '0;
    pulse_start();
    for (int k = 0; k < 32; k++) begin
      i_in_valid = 1'b1;
      i_in_data = 64'(100 + k);
      exp_sum = exp_sum + i_in_data;
      tick();
    end
    i_in_valid = 1'b0;
    total++;
    if (o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ab_reload_wait got ready=%b want=0", o_in_ready);
    end
    tick();
    total++;
    if (o_dec_start !== 1'b1 || wr_cnt - w0 != 32 || wr_sum - s0 !== exp_sum) begin
      bad++;
      $display("FAIL ab_reload got dec=%b writes=%0d sum=%h want 1/32/%h",
               o_dec_start, wr_cnt - w0, wr_sum - s0, exp_sum);
    end
    i_dec_done = 1'b1;
    tick();
    i_dec_done = 1'b0;
    total++;
    if (o_all_done !== 1'b1) begin
      bad++;
      $display("FAIL ab_done got=%b want=1", o_all_done);
    end
    tick();
  endtask

  task automatic test_spurious_and_reset();
    int a0;
    i_n_sel = 2'd0;
    i_num_frames = 8'd2;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      i_in_valid = 1'b1;
      i_in_data = 64'(k);
      tick();
    end
    i_in_valid = 1'b0;
    i_start = 1'b1;
    i_dec_done = 1'b1;
    i_n_sel = 2'd3;
    i_num_frames = 8'd1;
    tick();
    i_start = 1'b0;
    i_dec_done = 1'b0;
    total++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b1 || o_frame_idx !== 8'd0) begin
      bad++;
      $display("FAIL sp_hold got ready=%b busy=%b idx=%0d want 1/1/0", o_in_ready, o_busy, o_frame_idx);
    end
    for (int k = 5; k < 16; k++) begin
      i_in_valid = 1'b1;
      i_in_data = 64'(k);
      tick();
    end
    i_in_valid = 1'b0;
    total++;
    if (o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL sp_count got ready=%b want=0", o_in_ready);
    end
    tick();
    total++;
    if (o_dec_start !== 1'b1) begin
      bad++;
      $display("FAIL sp_dec got=%b want=1", o_dec_start);
    end
    i_dec_done = 1'b1;
    tick();
    i_dec_done = 1'b0;
    total++;
    if (o_frame_idx !== 8'd1 || o_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL sp_frames got idx=%0d ready=%b want 1/1", o_frame_idx, o_in_ready);
    end
    // Second frame, then reset while decoding it.
    for (int k = 0; k < 16; k++) begin
      i_in_valid = 1'b1;
      i_in_data = 64'(200 + k);
      tick();
    end
    i_in_valid = 1'b0;
    tick();
    tick();
    a0 = done_cnt;
    total++;
    if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rm_in_dec got busy=%b ready=%b want 1/0", o_busy, o_in_ready);
    end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    total++;
    if ({o_in_ready, o_mem_wen, o_dec_start, o_busy, o_all_done} !== 5'b0 ||
        o_mem_data !== 64'd0 || o_frame_idx !== 8'd0) begin
      bad++;
      $display("FAIL rm_reset got flags=%b data=%h idx=%0d want 00000/0/0",
               {o_in_ready, o_mem_wen, o_dec_start, o_busy, o_all_done}, o_mem_data, o_frame_idx);
    end
    i_dec_done = 1'b1;
    tick();
    i_dec_done = 1'b0;
    tick();
    total++;
    if (done_cnt != a0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL rm_after got dones=%0d busy=%b want 0/0", done_cnt - a0, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_zero_frames();
    test_abort();
    test_spurious_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/llr_loader.md
LLR_LOADER -- requirements
Module: llr_loader

Interface
REQ-001 Parameter: DATA_W, 64, input word width (8 LLRs x 8 bits, sign-magnitude).
REQ-002 Parameter: FRAME_W, 8, width of frame-count fields.
REQ-003 i_clk  input  1  clock; all logic is rising-edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_start  input  1  one-cycle job start pulse.
REQ-006 i_n_sel  input  2  code length select: 0=128, 1=256, 2=512, 3=1024 LLRs, i.e. 16/32/64/128 words.
REQ-007 i_num_frames  input  FRAME_W  frames in the job.
REQ-008 i_abort  input  1  synchronous job abort.
REQ-009 i_in_valid  input  1  upstream word valid.
REQ-010 i_in_data  input  DATA_W  upstream LLR word.
REQ-011 o_in_ready  output  1  loader accepts a word this cycle.
REQ-012 o_mem_wen  output  1  LLR memory shift-write enable.
REQ-013 o_mem_data  output  DATA_W  LLR memory write word.
REQ-014 o_dec_start  output  1  one-cycle pulse: frame fully loaded.
REQ-015 i_dec_done  input  1  one-cycle pulse: decoder finished the current frame.
REQ-016 o_frame_idx  output  FRAME_W  index of the frame being loaded or decoded.
REQ-017 o_busy  output  1  high in every state except IDLE.
REQ-018 o_all_done  output  1  one-cycle pulse: job complete.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, WAIT_MEM, DEC and DONE.
REQ-020 IDLE: on i_start with i_num_frames!=0, latch n_sel and num_frames, clear word_cnt and frame_idx, go to LOAD.
REQ-021 IDLE: on i_start with i_num_frames==0, go directly to DONE.
REQ-022 o_in_ready SHALL be high only in LOAD, combinationally from state alone, with no dependence on i_in_valid.
REQ-023 A word SHALL be accepted when i_in_valid && o_in_ready; a word not accepted SHALL have no effect.
REQ-024 For an accepted word in cycle T: o_mem_wen=1 and o_mem_data=i_in_data in cycle T+1 (registered), otherwise o_mem_wen=0 and o_mem_data holds its last value.
REQ-025 word_cnt SHALL increment per accepted word and SHALL wrap to 0 on accepting word (16<<n_sel)-1.
REQ-026 Accepting the last word of a frame in cycle T SHALL move the FSM to WAIT_MEM (T+1); o_dec_start=1 in T+2; the FSM enters DEC at T+2.
REQ-027 DEC: on i_dec_done, if frame_idx==num_frames-1, go to DONE; else increment frame_idx and go to LOAD.
REQ-028 DONE: o_all_done=1 for exactly that one cycle, then IDLE; frame_idx SHALL hold its final value until the next start.
REQ-029 i_start outside IDLE and i_dec_done outside DEC SHALL be ignored.
REQ-030 i_abort SHALL take priority over all events: next state IDLE, word_cnt=0, no o_dec_start or o_all_done generated, and any o_mem_wen already registered completes.
REQ-031 i_n_sel and i_num_frames SHALL be sampled only at an accepted start; later changes have no effect on the running job.
REQ-032 o_mem_data SHALL be passed through unmodified; sign-magnitude conversion belongs to the LLR memory.

Reset
REQ-033 While i_rst_n=0 at a clock edge: state=IDLE, word_cnt=0, frame_idx=0, latched config=0.
REQ-034 While i_rst_n=0 at a clock edge: o_mem_wen=0, o_mem_data=0, o_dec_start=0, o_all_done=0, o_busy=0, o_in_ready=0.
REQ-035 Reset asserted mid-job SHALL discard the job with no completion pulse.

Verification
REQ-036 n_sel=0, num_frames=1, valid held high with data=k -> 16 o_mem_wen cycles with data 0..15, each 1 cycle after acceptance; o_dec_start 2 cycles after the 16th acceptance; i_dec_done -> o_all_done one cycle later, o_busy low after that.
REQ-037 n_sel=3, num_frames=3, random valid gaps -> exactly 128 writes per frame, o_frame_idx steps 0,1,2, three o_dec_start pulses, ready low throughout DEC.
REQ-038 num_frames=0 start -> o_all_done pulse 1 cycle later, and no writes and no o_dec_start.
REQ-039 i_abort at word 10 of a 32-word frame -> IDLE next cycle, no further ready; new start reloads from word_cnt 0.
REQ-040 Spurious i_start during LOAD and i_dec_done during LOAD -> no state, count or config change.
REQ-041 i_rst_n low for 1 cycle during DEC -> all outputs at reset values and state IDLE after the edge.
